// File: rtl/ethernet_header_inserter_deadlock_ctrl.sv
// ethernet_header_inserter_deadlock_ctrl: qualifies sustained monitor stalls, snapshots the blocked set
// and reports it once over valid/ready while holding a sticky deadlock flag until cleared.
module ethernet_header_inserter_deadlock_ctrl #(
   parameter int NUM_MON   = 4,
   parameter int THRESHOLD = 1024,
   parameter int CNT_W     = 16,
   parameter int IDX_W     = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_MON-1:0] mon_block,
   input  logic               clear,
   output logic               deadlock,
   output logic               report_valid,
   input  logic               report_ready,
   output logic [NUM_MON-1:0] report_mask,
   output logic [IDX_W-1:0]   report_idx,
   output logic [7:0]         event_count
);
   typedef enum logic [1:0] {IDLE, MONITOR, REPORT, HOLD} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);
   localparam logic [CNT_W-1:0] TOP  = CNT_W'(THRESHOLD);
   state_t           state;
   logic [CNT_W-1:0] count;
   logic             any_block;
   logic [IDX_W-1:0] low_idx;
   assign any_block = |mon_block;
   // descending scan so the lowest set bit is the last one written
   always_comb begin
      low_idx = '0;
      for (int i = NUM_MON - 1; i >= 0; i--)
         if (mon_block[i]) low_idx = IDX_W'(i);
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         count        <= '0;
         deadlock     <= 1'b0;
         report_valid <= 1'b0;
         report_mask  <= '0;
         report_idx   <= '0;
         event_count  <= '0;
      end else if (clear) begin
         state        <= enable ? MONITOR : IDLE;
         count        <= '0;
         deadlock     <= 1'b0;
         report_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               count <= '0;
               if (enable) state <= MONITOR;
            end
            MONITOR: begin
               if (!enable) begin
                  state <= IDLE;
                  count <= '0;
               end else if (any_block && count == LAST) begin
                  state        <= REPORT;
                  count        <= TOP;
                  deadlock     <= 1'b1;
                  report_valid <= 1'b1;
                  report_mask  <= mon_block;
                  report_idx   <= low_idx;
               end else begin
                  count <= any_block ? count + CNT_W'(1) : '0;
               end
            end
            REPORT: begin
               if (report_ready) begin
                  state        <= HOLD;
                  report_valid <= 1'b0;
                  event_count  <= (event_count == 8'hff) ? event_count : event_count + 8'd1;
               end
            end
            HOLD: state <= HOLD;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ethernet_header_inserter_deadlock_ctrl.sv
// tb_ethernet_header_inserter_deadlock_ctrl: directed test-plan scenarios plus random stimulus,
// every cycle compared against a rule-level reference model of the supervisor.
module tb_ethernet_header_inserter_deadlock_ctrl;
   localparam int NM = 4;
   localparam int T  = 8;
   logic          clock = 1'b0;
   logic          reset, enable, clear, report_ready;
   logic [NM-1:0] mon_block;
   logic          deadlock, report_valid;
   logic [NM-1:0] report_mask;
   logic [3:0]    report_idx;
   logic [7:0]    event_count;
   int            checks = 0, errors = 0;
   bit            m_dead, m_pend, m_mon;
   int            m_run, m_idx, m_evt;
   logic [NM-1:0] m_mask;

   always #5 clock = ~clock;

   ethernet_header_inserter_deadlock_ctrl #(
      .NUM_MON(NM), .THRESHOLD(T), .CNT_W(16), .IDX_W(4)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .mon_block(mon_block),
      .clear(clear), .deadlock(deadlock), .report_valid(report_valid),
      .report_ready(report_ready), .report_mask(report_mask),
      .report_idx(report_idx), .event_count(event_count)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(logic [NM-1:0] v);
      for (int i = 0; i < NM; i++) if (v[i]) return i;
      return 0;
   endfunction

   // m_run counts consecutive blocked edges seen while supervising; a report fires on the T-th
   task automatic model_step();
      if (reset) begin
         m_dead = 0; m_pend = 0; m_mon = 0; m_run = 0; m_mask = '0; m_idx = 0; m_evt = 0;
      end else if (clear) begin
         m_dead = 0; m_pend = 0; m_run = 0; m_mon = enable;
      end else if (!m_dead) begin
         if (!m_mon) m_mon = enable;
         else if (!enable) begin m_mon = 0; m_run = 0; end
         else if (mon_block != 0) begin
            m_run++;
            if (m_run == T) begin
               m_dead = 1; m_pend = 1; m_mask = mon_block; m_idx = lowest(mon_block);
            end
         end else m_run = 0;
      end else if (m_pend && report_ready) begin
         m_pend = 0;
         if (m_evt < 255) m_evt++;
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      @(negedge clock);
      check("deadlock", 32'(deadlock), 32'(m_dead));
      check("report_valid", 32'(report_valid), 32'(m_pend));
      check("report_mask", 32'(report_mask), 32'(m_mask));
      check("report_idx", 32'(report_idx), 32'(m_idx));
      check("event_count", 32'(event_count), 32'(m_evt));
   endtask

   task automatic drive(logic r, logic e, logic c, logic rdy, logic [NM-1:0] mb, int n);
      reset = r; enable = e; clear = c; report_ready = rdy; mon_block = mb;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      m_dead = 0; m_pend = 0; m_mon = 0; m_run = 0; m_mask = '0; m_idx = 0; m_evt = 0;
      drive(1, 0, 0, 0, 4'b0000, 2);
      check("reset_deadlock", 32'(deadlock), 0);
      check("reset_events", 32'(event_count), 0);
      drive(0, 1, 0, 0, 4'b0000, 1);
      drive(0, 1, 0, 0, 4'b0100, T);
      check("tp1_deadlock", 32'(deadlock), 1);
      check("tp1_valid", 32'(report_valid), 1);
      check("tp1_mask", 32'(report_mask), 4);
      check("tp1_idx", 32'(report_idx), 2);
      drive(0, 1, 0, 1, 4'b0100, 1);
      check("tp1_valid_drop", 32'(report_valid), 0);
      check("tp1_events", 32'(event_count), 1);
      check("tp1_sticky", 32'(deadlock), 1);
      drive(0, 1, 1, 0, 4'b0000, 1);
      drive(0, 1, 0, 0, 4'b1001, T - 1);
      drive(0, 1, 0, 0, 4'b0000, 1);
      drive(0, 1, 0, 0, 4'b1001, T - 1);
      check("tp2_no_detect", 32'(deadlock), 0);
      drive(0, 1, 0, 0, 4'b1001, 1);
      check("tp2_detect", 32'(deadlock), 1);
      drive(0, 1, 0, 1, 4'b0000, 1);
      drive(0, 1, 1, 0, 4'b0000, 1);
      drive(0, 1, 0, 0, 4'b0010, 5);
      drive(0, 1, 0, 0, 4'b1010, 3);
      check("tp3_mask", 32'(report_mask), 10);
      check("tp3_idx", 32'(report_idx), 1);
      drive(0, 1, 0, 0, 4'b0001, 20);
      check("tp4_valid_held", 32'(report_valid), 1);
      check("tp4_mask_held", 32'(report_mask), 10);
      drive(0, 1, 1, 1, 4'b0001, 1);
      check("tp4_clear_dead", 32'(deadlock), 0);
      check("tp4_clear_valid", 32'(report_valid), 0);
      check("tp4_clear_events", 32'(event_count), 2);
      drive(0, 1, 0, 1, 4'b0001, T - 1);
      check("tp4_rearm", 32'(deadlock), 0);
      drive(0, 1, 0, 0, 4'b0001, 1);
      check("tp4_redetect", 32'(deadlock), 1);
      drive(0, 1, 1, 0, 4'b0000, 1);
      drive(0, 1, 0, 0, 4'b0110, T - 1);
      drive(0, 0, 0, 0, 4'b0110, 1);
      check("tp5_enable_prio", 32'(deadlock), 0);
      drive(0, 1, 0, 0, 4'b0110, 1);
      drive(0, 1, 0, 0, 4'b0110, T - 1);
      check("tp5_full_again", 32'(deadlock), 0);
      drive(0, 1, 0, 0, 4'b0110, 1);
      check("tp5_detect", 32'(deadlock), 1);
      drive(0, 1, 1, 0, 4'b0000, 1);
      for (int k = 0; k < 256; k++) begin
         drive(0, 1, 0, 0, NM'($urandom_range(1, 15)), T);
         drive(0, 1, 0, 1, 4'b0000, 1);
         drive(0, 1, 1, 0, 4'b0000, 1);
      end
      check("tp6_saturate", 32'(event_count), 255);
      drive(0, 1, 0, 0, 4'b1000, T);
      check("tp6_in_report", 32'(report_valid), 1);
      drive(1, 1, 0, 0, 4'b1000, 1);
      check("tp6_reset_dead", 32'(deadlock), 0);
      check("tp6_reset_valid", 32'(report_valid), 0);
      check("tp6_reset_mask", 32'(report_mask), 0);
      check("tp6_reset_events", 32'(event_count), 0);
      for (int k = 0; k < 3000; k++)
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
               $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? 4'b0000 : NM'($urandom_range(0, 15)), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
